// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store initiator between the MIPS memory stage and a word-addressed
// data RAM. It takes one request at a time and drives the RAM read/write
// strobes. Byte and halfword stores are done as a read-modify-write. It
// returns a one-cycle response carrying extended load data or an error flag.
//
// Optional feature macro: MAU_SUBWORD_EN
//   defined   : byte/halfword loads and stores, read-modify-write path
//   undefined : word accesses only; sub-word sizes return an error
//
// Parameters
//   MEM_WORDS       number of 32-bit words in the attached RAM
// Ports
//   clk, reset      clock, synchronous active-high reset
//   req_valid       request present
//   req_ready       unit idle, request will be accepted
//   req_we          1 = store, 0 = load
//   req_size        00 byte, 01 half, 10 word, 11 illegal
//   req_signed      sign-extend sub-word loads
//   req_addr        byte address
//   req_wdata       right-justified store data
//   resp_valid      one-cycle response pulse
//   resp_rdata      extended load data (0 for stores/errors)
//   resp_err        misaligned / out of range / illegal size
//   ram_address     word-aligned byte address to the RAM
//   ram_data_write  full word to write
//   ram_write_en    RAM write strobe
//   ram_read_en     RAM read enable
//   ram_data_out    combinational RAM read data
//
// state | meaning
// IDLE  | ready for a request
// READ  | RAM read, word captured (load, or first half of RMW)
// WRITE | RAM write of full or merged word
// RESP  | one-cycle response
module mem_access_unit #(
   parameter int MEM_WORDS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] ram_address,
   output logic [31:0] ram_data_write,
   output logic        ram_write_en,
   output logic        ram_read_en,
   input  logic [31:0] ram_data_out
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t      state, state_next;
   logic [31:0] addr_q, wdata_q, word_q;
   logic [1:0]  size_q;
   logic        we_q, signed_q, err_q;
   logic        accept, req_err, size_err, align_err, out_of_range;
   logic [31:0] load_data, store_data;

   assign accept = (state == IDLE) && req_valid;

   always_comb begin
      out_of_range = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
`ifdef MAU_SUBWORD_EN
      size_err  = (req_size == 2'b11);
      align_err = ((req_size == 2'b01) && req_addr[0]) ||
                  ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
      size_err  = (req_size != 2'b10);
      align_err = (req_addr[1:0] != 2'b00);
`endif
      req_err = size_err || align_err || out_of_range;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         word_q   <= '0;
         size_q   <= '0;
         we_q     <= 1'b0;
         signed_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (accept) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            size_q   <= req_size;
            we_q     <= req_we;
            signed_q <= req_signed;
            err_q    <= req_err;
         end
         if (state == READ) word_q <= ram_data_out;
      end
   end

`ifdef MAU_SUBWORD_EN
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_q[{addr_q[1:0], 3'b000} +: 8];
      half_sel = addr_q[1] ? word_q[31:16] : word_q[15:0];

      case (size_q)
         2'b00:   load_data = {{24{signed_q & byte_sel[7]}}, byte_sel};
         2'b01:   load_data = {{16{signed_q & half_sel[15]}}, half_sel};
         default: load_data = word_q;
      endcase

      // Merge the new lane(s) into the word captured in READ.
      store_data = word_q;
      case (size_q)
         2'b00:   store_data[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         2'b01: begin
            if (addr_q[1]) store_data[31:16] = wdata_q[15:0];
            else           store_data[15:0]  = wdata_q[15:0];
         end
         default: store_data = wdata_q;
      endcase
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{signed_q, size_q, addr_q[1:0]};
   assign load_data  = word_q;
   assign store_data = wdata_q;
`endif

   always_comb begin
      state_next     = state;
      req_ready      = 1'b0;
      resp_valid     = 1'b0;
      resp_rdata     = '0;
      resp_err       = 1'b0;
      ram_read_en    = 1'b0;
      ram_write_en   = 1'b0;
      ram_address    = '0;
      ram_data_write = '0;

      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_err)          state_next = RESP;
               else if (!req_we)     state_next = READ;
`ifdef MAU_SUBWORD_EN
               else if (req_size != 2'b10) state_next = READ;
`endif
               else                  state_next = WRITE;
            end
         end
         READ:    state_next = we_q ? WRITE : RESP;
         WRITE:   state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase

      // Outputs are held at their reset values while reset is high, which
      // also suppresses a write that was in flight.
      if (!reset) begin
         case (state)
            IDLE: req_ready = 1'b1;
            READ: begin
               ram_read_en = 1'b1;
               ram_address = {addr_q[31:2], 2'b00};
            end
            WRITE: begin
               ram_write_en   = 1'b1;
               ram_address    = {addr_q[31:2], 2'b00};
               ram_data_write = store_data;
            end
            RESP: begin
               resp_valid = 1'b1;
               resp_err   = err_q;
               resp_rdata = (!we_q && !err_q) ? load_data : '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios with literal expectations
// plus randomized requests checked against a behavioural memory model.
module tb_mem_access_unit;

   localparam int MEM_WORDS = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] ram_address, ram_data_write, ram_data_out;
   logic        ram_write_en, ram_read_en;
   logic        ram_clear;

   logic [31:0] ram [0:MEM_WORDS-1];
   logic [31:0] mdl [0:MEM_WORDS-1];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .ram_address(ram_address), .ram_data_write(ram_data_write),
      .ram_write_en(ram_write_en), .ram_read_en(ram_read_en),
      .ram_data_out(ram_data_out)
   );

   assign ram_data_out = ram[ram_address[6:2]];

   always @(posedge clk) begin
      if (ram_clear) begin
         for (int i = 0; i < MEM_WORDS; i++) ram[i] <= '0;
      end else if (ram_write_en) begin
         ram[ram_address[6:2]] <= ram_data_write;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Behavioural model: the outcome of one request against the shadow memory.
   task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic err, output logic [31:0] rdata, output int lat,
                        output int n_rd, output int n_wr, output logic [31:0] wword);
      int unsigned w, off;
      logic [31:0] old, mask, v;
      w = addr / 4;
      off = addr % 4;
      err = 1'b0;
      if (size == 2'd3) err = 1'b1;
`ifndef MAU_SUBWORD_EN
      if (size != 2'd2) err = 1'b1;
`endif
      if (size == 2'd1 && (off % 2) != 0) err = 1'b1;
      if (size == 2'd2 && off != 0) err = 1'b1;
      if (w >= MEM_WORDS) err = 1'b1;
      rdata = '0; wword = '0; n_rd = 0; n_wr = 0; lat = 1;
      if (!err) begin
         old = mdl[w];
         if (we) begin
            if (size == 2'd2) begin
               wword = wdata;
               lat = 2;
            end else begin
               mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
               wword = (old & ~mask) | ((wdata << (8 * off)) & mask);
               lat = 3;
               n_rd = 1;
            end
            n_wr = 1;
            mdl[w] = wword;
         end else begin
            n_rd = 1;
            lat = 2;
            v = old >> (8 * off);
            if (size == 2'd0) begin
               rdata = {24'h0, v[7:0]};
               if (sgn && v[7]) rdata = rdata | 32'hFFFFFF00;
            end else if (size == 2'd1) begin
               rdata = {16'h0, v[15:0]};
               if (sgn && v[15]) rdata = rdata | 32'hFFFF0000;
            end else begin
               rdata = old;
            end
         end
      end
   endtask

   // Issue one request at a negedge, then check every cycle until the unit is
   // idle again. Returns what the DUT responded with.
   task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] got_rdata, output logic got_err,
                         output int got_lat);
      logic        e_err;
      logic [31:0] e_rdata, e_wword;
      int          e_lat, e_rd, e_wr, rd, wr, n;
      req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
      req_addr = addr; req_wdata = wdata;
      n = 0;
      while (!req_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_accept", 32'(req_ready), 32'd1);
      model(we, size, sgn, addr, wdata, e_err, e_rdata, e_lat, e_rd, e_wr, e_wword);
      @(posedge clk);
      #1;
      // Garbage while busy must be ignored.
      req_valid = 1'($urandom);
      req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      got_rdata = '0; got_err = 1'b0; got_lat = 0; rd = 0; wr = 0;
      for (int k = 1; k <= e_lat + 1; k++) begin
         @(negedge clk);
         if (k == e_lat + 1) req_valid = 1'b0;
         chk("resp_valid", 32'(resp_valid), 32'(k == e_lat));
         chk("rd_wr_exclusive", 32'(ram_read_en & ram_write_en), 32'd0);
         if (ram_read_en) begin
            rd++;
            chk("rd_addr", ram_address, {addr[31:2], 2'b00});
         end
         if (ram_write_en) begin
            wr++;
            chk("wr_addr", ram_address, {addr[31:2], 2'b00});
            chk("wr_data", ram_data_write, e_wword);
         end
         if (resp_valid) begin
            got_rdata = resp_rdata;
            got_err = resp_err;
            got_lat = k;
            chk("resp_rdata", resp_rdata, e_rdata);
            chk("resp_err", 32'(resp_err), 32'(e_err));
         end
         if (k == e_lat + 1) chk("ready_after_resp", 32'(req_ready), 32'd1);
      end
      chk("n_reads", 32'(rd), 32'(e_rd));
      chk("n_writes", 32'(wr), 32'(e_wr));
      if (!e_err) chk("ram_word", ram[addr[6:2]], mdl[addr[6:2]]);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
      chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
      chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
      chk({tag, "_ram_read_en"}, 32'(ram_read_en), 32'd0);
      chk({tag, "_ram_write_en"}, 32'(ram_write_en), 32'd0);
      chk({tag, "_ram_address"}, ram_address, 32'd0);
      chk({tag, "_ram_data_write"}, ram_data_write, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd_v;
      logic        er_v;
      int          lt_v;
      logic [31:0] keep;
      int          wcyc;
      logic [1:0]  sz;
      logic [31:0] a;
      int          r;

      for (int i = 0; i < MEM_WORDS; i++) mdl[i] = '0;
      reset = 1'b1; ram_clear = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
      req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");
      reset = 1'b0; ram_clear = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 32'(req_ready), 32'd1);

      // Word store then word load.
      do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, rd_v, er_v, lt_v);
      chk("lit_wstore_lat", 32'(lt_v), 32'd2);
      chk("lit_wstore_ram", ram[2], 32'hDEADBEEF);
      do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, rd_v, er_v, lt_v);
      chk("lit_wload_data", rd_v, 32'hDEADBEEF);
      chk("lit_wload_err", 32'(er_v), 32'd0);
      chk("lit_wload_lat", 32'(lt_v), 32'd2);

`ifdef MAU_SUBWORD_EN
      // Byte store read-modify-write.
      do_req(1'b1, 2'b10, 1'b0, 32'h04, 32'h11223344, rd_v, er_v, lt_v);
      do_req(1'b1, 2'b00, 1'b0, 32'h06, 32'h000000AA, rd_v, er_v, lt_v);
      chk("lit_bstore_lat", 32'(lt_v), 32'd3);
      chk("lit_bstore_ram", ram[1], 32'h11AA3344);

      // Signed / unsigned sub-word loads.
      do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'h8001FFFE, rd_v, er_v, lt_v);
      do_req(1'b0, 2'b01, 1'b1, 32'h0A, 32'h0, rd_v, er_v, lt_v);
      chk("lit_lh_signed", rd_v, 32'hFFFF8001);
      chk("lit_lh_lat", 32'(lt_v), 32'd2);
      do_req(1'b0, 2'b01, 1'b0, 32'h0A, 32'h0, rd_v, er_v, lt_v);
      chk("lit_lh_unsigned", rd_v, 32'h00008001);
      do_req(1'b0, 2'b00, 1'b1, 32'h08, 32'h0, rd_v, er_v, lt_v);
      chk("lit_lb_signed", rd_v, 32'hFFFFFFFE);
      do_req(1'b0, 2'b01, 1'b0, 32'h09, 32'h0, rd_v, er_v, lt_v);
      chk("lit_lh_misaligned_err", 32'(er_v), 32'd1);
`else
      do_req(1'b0, 2'b00, 1'b0, 32'h00, 32'h0, rd_v, er_v, lt_v);
      chk("lit_nosub_lb_err", 32'(er_v), 32'd1);
      chk("lit_nosub_lb_lat", 32'(lt_v), 32'd1);
      do_req(1'b1, 2'b01, 1'b0, 32'h00, 32'h1234, rd_v, er_v, lt_v);
      chk("lit_nosub_sh_err", 32'(er_v), 32'd1);
`endif

      // Error cases and the range boundary.
      do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, rd_v, er_v, lt_v);
      chk("lit_misaligned_err", 32'(er_v), 32'd1);
      chk("lit_misaligned_lat", 32'(lt_v), 32'd1);
      do_req(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, rd_v, er_v, lt_v);
      chk("lit_range_err", 32'(er_v), 32'd1);
      do_req(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, rd_v, er_v, lt_v);
      chk("lit_size3_err", 32'(er_v), 32'd1);
      do_req(1'b1, 2'b10, 1'b0, 32'h7C, 32'hCAFEF00D, rd_v, er_v, lt_v);
      do_req(1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, rd_v, er_v, lt_v);
      chk("lit_last_word", rd_v, 32'hCAFEF00D);
      chk("lit_last_word_err", 32'(er_v), 32'd0);

      // Reset during the WRITE cycle: write suppressed, no response.
      keep = ram[1];
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_signed = 1'b0;
      req_addr = 32'h05; req_wdata = 32'h00000055;
`ifdef MAU_SUBWORD_EN
      req_size = 2'b00; wcyc = 2;
`else
      req_addr = 32'h04; req_size = 2'b10; wcyc = 1;
`endif
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int k = 1; k <= wcyc; k++) @(negedge clk);
      chk("rst_mid_write_before", 32'(ram_write_en), 32'd1);
      reset = 1'b1;
      #1 chk("rst_mid_write_gated", 32'(ram_write_en), 32'd0);
      @(negedge clk);
      chk_outputs_zero("rst_mid");
      reset = 1'b0;
      @(negedge clk);
      chk("rst_mid_ready", 32'(req_ready), 32'd1);
      chk("rst_mid_no_resp", 32'(resp_valid), 32'd0);
      chk("rst_mid_ram_kept", ram[1], keep);
      chk("rst_mid_ram_model", ram[1], mdl[1]);

      // Randomized traffic against the model.
      for (int t = 0; t < 200; t++) begin
         r = int'($urandom_range(0, 9));
         sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         if ($urandom_range(0, 15) == 0) a = $urandom;
         else a = 32'($urandom_range(0, MEM_WORDS * 4 + 15));
         do_req(1'($urandom), sz, 1'($urandom), a, $urandom, rd_v, er_v, lt_v);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the MIPS memory stage and the word-addressed data RAM. Accepts one load or store request at a time from the pipeline. Sequences the RAM's `read_en`/`write_en` port, including read-modify-write for byte and halfword stores. Returns a single-cycle response with extended load data or an error flag.

## Interface
Parameters:
- `MEM_WORDS`, default 32: number of 32-bit words in the attached RAM. Word index `addr>>2 >= MEM_WORDS` is out of range.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` in 1: clock.
  - `reset` in 1: synchronous, active-high reset.
- Pipeline request side:
  - `req_valid` in 1: request present.
  - `req_ready` out 1: unit idle and able to accept.
  - `req_we` in 1: 1 = store, 0 = load.
  - `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
  - `req_signed` in 1: sign-extend sub-word loads.
  - `req_addr` in 32: byte address.
  - `req_wdata` in 32: store data, right-justified.
- Pipeline response side:
  - `resp_valid` out 1: one-cycle response pulse.
  - `resp_rdata` out 32: extended load data; 0 for stores and errors.
  - `resp_err` out 1: misaligned, out-of-range or illegal size; valid with `resp_valid`.
- RAM side:
  - `ram_address` out 32: word-aligned byte address (`addr[1:0]` forced to 00).
  - `ram_data_write` out 32: full word to write.
  - `ram_write_en` out 1: write strobe; RAM commits at the clock edge.
  - `ram_read_en` out 1: read enable.
  - `ram_data_out` in 32: combinational read data from the RAM.

## Operation
- Byte lanes are little-endian: byte offset 0 = bits 7:0, offset 3 = bits 31:24; halfword offset 2 = bits 31:16.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch addr/size/we/signed/wdata, then:
  - error detected (size 11, half with `addr[0]`=1, word with `addr[1:0]`≠0, or out of range) → RESP with error; no RAM access.
  - load → READ.
  - word store → WRITE.
  - byte/half store → READ.
- READ: `ram_read_en`=1 and `ram_address` driven; `ram_data_out` captured into a word register at the clock edge. Next state is WRITE for a store, RESP for a load.
- WRITE: `ram_write_en`=1. `ram_data_write` is `req_wdata` for word stores. For sub-word stores it is the captured word with the selected lane(s) replaced by `req_wdata[7:0]` or `[15:0]`. Next state is RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then unconditionally IDLE. No response back-pressure.
  - load: selected lane zero- or sign-extended per `req_signed`.
- `ram_read_en`/`ram_write_en` are never both 1. Both are 0 in IDLE and RESP.
- `req_valid` outside IDLE is ignored; the requester must hold the request until it sees `req_ready`.

## Timing
- Accept edge = edge where `req_valid && req_ready`.
- Latency from accept edge to `resp_valid` high:
  - word load: 2 cycles.
  - word store: 2 cycles.
  - byte/half store: 3 cycles.
  - sub-word load: 2 cycles.
  - error: 1 cycle.
- `req_ready` returns high the cycle after RESP; the next request can be accepted then.
- Reset values (outputs forced while `reset`=1, then state IDLE): `req_ready`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `ram_read_en`=0, `ram_write_en`=0, `ram_address`=0, `ram_data_write`=0.
- Reset mid-operation: the transaction is dropped with no response. An in-flight WRITE is suppressed because `ram_write_en` is gated low during reset. `req_ready`=1 on the first cycle after reset deasserts.

## Configuration
- `MAU_SUBWORD_EN` defined:
  - byte/halfword loads and stores supported.
  - read-modify-write path present.
- Not defined:
  - only `req_size`=10 is legal; sizes 00/01 produce `resp_err`=1 after 1 cycle with no RAM access.
  - READ is entered only for loads; the merge logic and `req_signed` are unused.

## Test plan
- Word store then word load: store addr 0x08, data 0xDEADBEEF.
  - Expect `ram_write_en` for one cycle with `ram_address`=0x08.
  - Then a load of 0x08 returns 0xDEADBEEF, `resp_err`=0, 2 cycles after accept.
- Byte store read-modify-write: RAM word 1 = 0x11223344; store byte 0xAA at addr 0x06.
  - Expect a READ cycle then WRITE with `ram_data_write`=0x11AA3344; response 3 cycles after accept.
- Signed halfword load: RAM word 2 = 0x8001FFFE.
  - Load half addr 0x0A signed returns 0xFFFF8001.
  - Unsigned returns 0x00008001.
  - Byte 0x08 signed returns 0xFFFFFFFE.
- Errors:
  - word load at 0x06 → `resp_err`=1 after 1 cycle, no `ram_read_en` pulse.
  - with `MEM_WORDS`=32, load at 0x80 → `resp_err`=1.
  - `req_size`=11 → `resp_err`=1.
- Reset during the WRITE cycle of a byte store: `ram_write_en`=0 that cycle and the RAM word is unchanged. `req_ready`=1 the cycle after reset falls, with no `resp_valid`.
- Build without `MAU_SUBWORD_EN`: byte load at 0x00 → `resp_err`=1 after 1 cycle; word accesses behave as in the first scenario.
